spi_char_writer: RTL

SPI_CHAR_WRITER -- requirements
Module: spi_char_writer

---
 rtl/spi_char_writer_pkg.sv | 25 ++
 rtl/spi_byte_rx.sv | 81 ++++++++
 rtl/spi_char_writer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_char_writer_pkg.sv
// Shared types and constants for the SPI character writer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_char_writer_pkg;

    // Frame-level controller states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_DATA  = 3'd2,
        ST_CLR   = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    // Command byte layout: bit 7 set selects a write with a start address
    localparam int          CMD_WRITE_BIT = 7;
    localparam logic [7:0]  CMD_CLEAR     = 8'h00;
    localparam logic [7:0]  CLEAR_CHAR    = 8'h20;

    // Character address advance with wrap at the last RAM location
    function automatic logic [7:0] next_addr(input logic [7:0] addr, input logic [7:0] addr_max);
        return (addr == addr_max) ? 8'd0 : addr + 8'd1;
    endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// SPI mode-0 byte receiver: synchronises sclk/cs_n/mosi and assembles MSB-first bytes.
// Latency: byte_valid pulses 3 clk after the 8th sclk rising edge reaches the pins.
// Backpressure: none; byte_valid is a one-clk pulse that must be consumed immediately.
module spi_byte_rx (
    input  logic       clk,
    input  logic       sysrst,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       cs_active
`ifdef SPI_ECHO_EN
    ,
    output logic       sclk_fall
`endif
);

    logic       sclk_meta_q, sclk_s_q, sclk_prev_q;
    logic       cs_meta_q, cs_s_q;
    logic       mosi_meta_q, mosi_s_q;
    logic [2:0] bit_cnt_q;
    logic [6:0] shift_q;
    logic       byte_valid_q;
    logic [7:0] byte_data_q;
    logic       sclk_rise;

    // Two-flop synchronisers, reset to the idle bus levels
    always_ff @(posedge clk or negedge sysrst) begin
        if (!sysrst) begin
            sclk_meta_q <= 1'b0;
            sclk_s_q    <= 1'b0;
            sclk_prev_q <= 1'b0;
            cs_meta_q   <= 1'b1;
            cs_s_q      <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_s_q    <= 1'b0;
        end else begin
            sclk_meta_q <= spi_sclk;
            sclk_s_q    <= sclk_meta_q;
            sclk_prev_q <= sclk_s_q;
            cs_meta_q   <= spi_cs_n;
            cs_s_q      <= cs_meta_q;
            mosi_meta_q <= spi_mosi;
            mosi_s_q    <= mosi_meta_q;
        end
    end

    // mosi and sclk share the same synchroniser depth, so mosi_s_q is the bit sampled at the edge
    assign sclk_rise = sclk_s_q & ~sclk_prev_q;

    // Bit/byte assembly; any partial byte is thrown away while cs_n is high
    always_ff @(posedge clk or negedge sysrst) begin
        if (!sysrst) begin
            bit_cnt_q    <= 3'd0;
            shift_q      <= 7'd0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= 8'd0;
        end else begin
            byte_valid_q <= 1'b0;
            if (cs_s_q) begin
                bit_cnt_q <= 3'd0;
            end else if (sclk_rise) begin
                shift_q   <= {shift_q[5:0], mosi_s_q};
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    byte_valid_q <= 1'b1;
                    byte_data_q  <= {shift_q, mosi_s_q};
                end
            end
        end
    end

    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;
    assign cs_active  = ~cs_s_q;
`ifdef SPI_ECHO_EN
    assign sclk_fall  = ~sclk_s_q & sclk_prev_q;
`endif

endmodule

// File: rtl/spi_char_writer.sv
// SPI command decoder writing a character RAM and requesting LCD refresh; optional echo via SPI_ECHO_EN.
// Latency: wren one clk after each completed data byte; update one clk after the frame's final write.
// Backpressure: none; RAM accepts every write strobe, SPI bytes in CLR/DRAIN are discarded.
module spi_char_writer
    import spi_char_writer_pkg::*;
#(
    parameter int CHAR_COUNT = 32,
    parameter int UPD_WIDTH  = 16
) (
    input  logic       clk,
    input  logic       sysrst,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic [7:0] wr_data,
    output logic [7:0] wr_addr,
    output logic       wren,
    output logic       update,
    output logic       frame_err
);

    localparam logic [7:0] ADDR_MAX = 8'(CHAR_COUNT - 1);
    localparam int         UCW      = $clog2(UPD_WIDTH + 1);
    localparam logic [UCW-1:0] UPD_LOAD = UCW'(UPD_WIDTH - 1);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       cs_active;
    logic       cs_prev_q;
    logic       cs_fall, cs_rise;

    state_e     state_q;
    logic [7:0] addr_q;
    logic       wrote_q;
    logic [1:0] settle_q;
    logic       wren_q, frame_err_q, upd_start_q;
    logic [7:0] wr_data_q, wr_addr_q;
    logic       update_q;
    logic [UCW-1:0] upd_cnt_q;

`ifdef SPI_ECHO_EN
    logic       sclk_fall;
`endif

    spi_byte_rx u_rx (
        .clk        (clk),
        .sysrst     (sysrst),
        .spi_sclk   (spi_sclk),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .cs_active  (cs_active)
`ifdef SPI_ECHO_EN
        ,
        .sclk_fall  (sclk_fall)
`endif
    );

    assign cs_fall = cs_active & ~cs_prev_q;
    assign cs_rise = ~cs_active & cs_prev_q;

    // Frame controller with registered RAM-write and error outputs.
    // settle_q masks the synchroniser catching up after reset so a cs_n held low
    // through reset is not mistaken for a new frame start.
    always_ff @(posedge clk or negedge sysrst) begin
        if (!sysrst) begin
            state_q     <= ST_IDLE;
            addr_q      <= 8'd0;
            wrote_q     <= 1'b0;
            settle_q    <= 2'd0;
            cs_prev_q   <= 1'b0;
            wren_q      <= 1'b0;
            frame_err_q <= 1'b0;
            upd_start_q <= 1'b0;
            wr_data_q   <= 8'd0;
            wr_addr_q   <= 8'd0;
        end else begin
            wren_q      <= 1'b0;
            frame_err_q <= 1'b0;
            upd_start_q <= 1'b0;
            cs_prev_q   <= cs_active;
            if (settle_q != 2'd3) begin
                settle_q <= settle_q + 2'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall && settle_q == 2'd3) begin
                        state_q <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (cs_rise) begin
                        state_q <= ST_IDLE;
                    end else if (byte_valid) begin
                        if (byte_data[CMD_WRITE_BIT] && ({1'b0, byte_data[6:0]} <= ADDR_MAX)) begin
                            addr_q  <= {1'b0, byte_data[6:0]};
                            wrote_q <= 1'b0;
                            state_q <= ST_DATA;
                        end else if (byte_data == CMD_CLEAR) begin
                            addr_q  <= 8'd0;
                            state_q <= ST_CLR;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_DRAIN;
                        end
                    end
                end
                ST_DATA: begin
                    if (byte_valid) begin
                        wren_q    <= 1'b1;
                        wr_data_q <= byte_data;
                        wr_addr_q <= addr_q;
                        addr_q    <= next_addr(addr_q, ADDR_MAX);
                        wrote_q   <= 1'b1;
                    end
                    if (cs_rise) begin
                        state_q     <= ST_IDLE;
                        upd_start_q <= wrote_q | byte_valid;
                    end
                end
                ST_CLR: begin
                    wren_q    <= 1'b1;
                    wr_data_q <= CLEAR_CHAR;
                    wr_addr_q <= addr_q;
                    addr_q    <= next_addr(addr_q, ADDR_MAX);
                    if (addr_q == ADDR_MAX) begin
                        upd_start_q <= 1'b1;
                        state_q     <= cs_active ? ST_DRAIN : ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (cs_rise) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Update pulse stretcher; a fresh request restarts the full width
    always_ff @(posedge clk or negedge sysrst) begin
        if (!sysrst) begin
            update_q  <= 1'b0;
            upd_cnt_q <= '0;
        end else if (upd_start_q) begin
            update_q  <= 1'b1;
            upd_cnt_q <= UPD_LOAD;
        end else if (update_q) begin
            if (upd_cnt_q == '0) begin
                update_q <= 1'b0;
            end else begin
                upd_cnt_q <= upd_cnt_q - 1'b1;
            end
        end
    end

`ifdef SPI_ECHO_EN
    logic [7:0] echo_sr_q, echo_next_q;
    logic       echo_load_q;

    // Echo shifter: presents the previous byte MSB first, advancing on sclk falling edges
    always_ff @(posedge clk or negedge sysrst) begin
        if (!sysrst) begin
            echo_sr_q   <= 8'd0;
            echo_next_q <= 8'd0;
            echo_load_q <= 1'b0;
        end else if (cs_fall) begin
            echo_sr_q   <= 8'd0;
            echo_next_q <= 8'd0;
            echo_load_q <= 1'b0;
        end else begin
            if (byte_valid) begin
                echo_next_q <= byte_data;
                echo_load_q <= 1'b1;
            end
            if (sclk_fall && cs_active) begin
                if (echo_load_q) begin
                    echo_sr_q   <= echo_next_q;
                    echo_load_q <= 1'b0;
                end else begin
                    echo_sr_q <= {echo_sr_q[6:0], 1'b0};
                end
            end
        end
    end

    assign spi_miso = echo_sr_q[7];
`else
    assign spi_miso = 1'b0;
`endif

    assign wren      = wren_q;
    assign wr_data   = wr_data_q;
    assign wr_addr   = wr_addr_q;
    assign frame_err = frame_err_q;
    assign update    = update_q;

endmodule
